// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and width helpers for the register-hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    localparam int SB_AWIDTH_DEF = 5;
    localparam int SB_LAT_DEF    = 3;
    localparam int SB_KILL_DEF   = 1;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_RF = 0;

    // Forwarding select width: SEL_W = $clog2(LAT), never below one bit.
    function automatic int sb_sel_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    // Pending counter width: CNT_W = $clog2(LAT+1), enough to count every slot.
    function automatic int sb_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/sb_slot_match.sv
// Per-slot source comparator: flags rs/rt address hits against one live slot.
// Latency: purely combinational.
// Backpressure: none; the caller decides what a hit means.
module sb_slot_match #(
    parameter int AWIDTH = 5
) (
    input  logic              slot_vld_i,
    input  logic [AWIDTH-1:0] slot_addr_i,
    input  logic              slot_load_i,
    input  logic [AWIDTH-1:0] rs_addr_i,
    input  logic [AWIDTH-1:0] rt_addr_i,
    output logic              rs_hit_o,
    output logic              rt_hit_o,
    output logic              is_load_o
);

    assign rs_hit_o  = slot_vld_i && (slot_addr_i == rs_addr_i);
    assign rt_hit_o  = slot_vld_i && (slot_addr_i == rt_addr_i);
    assign is_load_o = slot_vld_i && slot_load_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard between decode and execute; optional forwarding via SCOREBOARD_FORWARD_EN.
// Latency: issue_ready/stall/fwd selects are combinational; an entry retires LAT advancing edges after issue.
// Backpressure: ready drops on hazard, flush, reset or ce=0; stall = issue_valid && !ready.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AWIDTH      = SB_AWIDTH_DEF,
    parameter int LAT         = SB_LAT_DEF,
    parameter int KILL_STAGES = SB_KILL_DEF
) (
    input  logic                     sb_clk,
    input  logic                     sb_rst,
    input  logic                     sb_i_ce,
    input  logic                     sb_i_issue_valid,
    output logic                     sb_o_issue_ready,
    input  logic [AWIDTH-1:0]        sb_i_rs_addr,
    input  logic [AWIDTH-1:0]        sb_i_rt_addr,
    input  logic                     sb_i_rs_used,
    input  logic                     sb_i_rt_used,
    input  logic [AWIDTH-1:0]        sb_i_dst_addr,
    input  logic                     sb_i_RegWrite,
    input  logic                     sb_i_MemRead,
    input  logic                     sb_i_flush,
    output logic                     sb_o_stall,
    output logic                     sb_o_wb_valid,
    output logic [AWIDTH-1:0]        sb_o_wb_addr,
    output logic [$clog2(LAT+1)-1:0] sb_o_pending_cnt,
    output logic [$clog2(LAT)-1:0]   sb_o_fwd_rs_sel,
    output logic [$clog2(LAT)-1:0]   sb_o_fwd_rt_sel
);

    localparam int SEL_W = sb_sel_w(LAT);
    localparam int CNT_W = sb_cnt_w(LAT);

    typedef struct packed {
        logic              vld;
        logic [AWIDTH-1:0] addr;
        logic              is_load;
    } slot_t;

    slot_t slot_q [LAT];
    slot_t slot_d [LAT];
    slot_t kill_s [LAT];
    slot_t new_slot;

    logic [LAT-2:0] rs_hit;
    logic [LAT-2:0] rt_hit;
    logic [LAT-2:0] slot_ld;
    logic           rs_chk;
    logic           rt_chk;
    logic           hazard;
    logic           fire;
    logic [CNT_W-1:0] cnt;

    // Slot LAT-1 is retiring and the regfile is write-first, so only younger slots can hazard.
    for (genvar g = 0; g < LAT - 1; g++) begin : g_match
        sb_slot_match #(.AWIDTH(AWIDTH)) u_match (
            .slot_vld_i  (slot_q[g].vld),
            .slot_addr_i (slot_q[g].addr),
            .slot_load_i (slot_q[g].is_load),
            .rs_addr_i   (sb_i_rs_addr),
            .rt_addr_i   (sb_i_rt_addr),
            .rs_hit_o    (rs_hit[g]),
            .rt_hit_o    (rt_hit[g]),
            .is_load_o   (slot_ld[g])
        );
    end

    // r0 is hardwired zero and unused sources never create a dependency.
    assign rs_chk = sb_i_rs_used && (|sb_i_rs_addr);
    assign rt_chk = sb_i_rt_used && (|sb_i_rt_addr);

`ifdef SCOREBOARD_FORWARD_EN
    logic [SEL_W-1:0] rs_sel;
    logic [SEL_W-1:0] rt_sel;
    logic             rs_ld0;
    logic             rt_ld0;

    // Youngest matching slot wins: scan oldest to youngest so slot 0 is written last.
    always_comb begin
        rs_sel = SEL_W'(FWD_RF);
        rt_sel = SEL_W'(FWD_RF);
        rs_ld0 = 1'b0;
        rt_ld0 = 1'b0;
        for (int k = LAT - 2; k >= 0; k--) begin
            if (rs_hit[k]) begin
                rs_sel = SEL_W'(k + 1);
                rs_ld0 = (k == 0) && slot_ld[k];
            end
            if (rt_hit[k]) begin
                rt_sel = SEL_W'(k + 1);
                rt_ld0 = (k == 0) && slot_ld[k];
            end
        end
    end

    // Only a load still in slot 0 has no data to forward yet.
    assign hazard          = (rs_chk && rs_ld0) || (rt_chk && rt_ld0);
    assign sb_o_fwd_rs_sel = rs_chk ? rs_sel : SEL_W'(FWD_RF);
    assign sb_o_fwd_rt_sel = rt_chk ? rt_sel : SEL_W'(FWD_RF);
`else
    logic unused_ld;

    assign hazard          = (rs_chk && (|rs_hit)) || (rt_chk && (|rt_hit));
    assign sb_o_fwd_rs_sel = SEL_W'(FWD_RF);
    assign sb_o_fwd_rt_sel = SEL_W'(FWD_RF);
    assign unused_ld       = ^slot_ld;
`endif

    assign sb_o_issue_ready = !sb_rst && sb_i_ce && !hazard && !sb_i_flush;
    assign sb_o_stall       = !sb_rst && sb_i_issue_valid && !sb_o_issue_ready;
    assign fire             = sb_i_issue_valid && sb_o_issue_ready;

    // Build the entry for slot 0; non-writing and r0-writing issues leave an empty slot.
    always_comb begin
        new_slot = '0;
        if (fire && sb_i_RegWrite && (|sb_i_dst_addr)) begin
            new_slot.vld     = 1'b1;
            new_slot.addr    = sb_i_dst_addr;
            new_slot.is_load = sb_i_MemRead;
        end
    end

    // Flush kills the youngest slots first, then the pipe shifts only when ce is high.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            kill_s[k] = slot_q[k];
            if (sb_i_flush && (k < KILL_STAGES)) begin
                kill_s[k].vld = 1'b0;
            end
        end
        for (int k = 0; k < LAT; k++) begin
            slot_d[k] = kill_s[k];
        end
        if (sb_i_ce) begin
            slot_d[0] = new_slot;
            for (int k = 1; k < LAT; k++) begin
                slot_d[k] = kill_s[k-1];
            end
        end
    end

    // Slot pipeline register; reset empties every slot immediately.
    always_ff @(posedge sb_clk or posedge sb_rst) begin
        if (sb_rst) begin
            for (int k = 0; k < LAT; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // Live-entry count across all slots including the retiring one.
    always_comb begin
        cnt = '0;
        for (int k = 0; k < LAT; k++) begin
            cnt = cnt + CNT_W'(slot_q[k].vld);
        end
    end

    assign sb_o_pending_cnt = cnt;
    assign sb_o_wb_valid    = slot_q[LAT-1].vld;
    assign sb_o_wb_addr     = slot_q[LAT-1].addr;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (AWIDTH=5, LAT=3, KILL_STAGES=1).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expected values are hand-derived from the slot pipeline behaviour.
module tb_hazard_scoreboard;

    logic       sb_clk;
    logic       sb_rst;
    logic       sb_i_ce;
    logic       sb_i_issue_valid;
    logic       sb_o_issue_ready;
    logic [4:0] sb_i_rs_addr;
    logic [4:0] sb_i_rt_addr;
    logic       sb_i_rs_used;
    logic       sb_i_rt_used;
    logic [4:0] sb_i_dst_addr;
    logic       sb_i_RegWrite;
    logic       sb_i_MemRead;
    logic       sb_i_flush;
    logic       sb_o_stall;
    logic       sb_o_wb_valid;
    logic [4:0] sb_o_wb_addr;
    logic [1:0] sb_o_pending_cnt;
    logic [1:0] sb_o_fwd_rs_sel;
    logic [1:0] sb_o_fwd_rt_sel;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .sb_clk           (sb_clk),
        .sb_rst           (sb_rst),
        .sb_i_ce          (sb_i_ce),
        .sb_i_issue_valid (sb_i_issue_valid),
        .sb_o_issue_ready (sb_o_issue_ready),
        .sb_i_rs_addr     (sb_i_rs_addr),
        .sb_i_rt_addr     (sb_i_rt_addr),
        .sb_i_rs_used     (sb_i_rs_used),
        .sb_i_rt_used     (sb_i_rt_used),
        .sb_i_dst_addr    (sb_i_dst_addr),
        .sb_i_RegWrite    (sb_i_RegWrite),
        .sb_i_MemRead     (sb_i_MemRead),
        .sb_i_flush       (sb_i_flush),
        .sb_o_stall       (sb_o_stall),
        .sb_o_wb_valid    (sb_o_wb_valid),
        .sb_o_wb_addr     (sb_o_wb_addr),
        .sb_o_pending_cnt (sb_o_pending_cnt),
        .sb_o_fwd_rs_sel  (sb_o_fwd_rs_sel),
        .sb_o_fwd_rt_sel  (sb_o_fwd_rt_sel)
    );

    initial sb_clk = 1'b0;
    always #5 sb_clk = ~sb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] dst, input logic rw, input logic ld,
                         input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu);
        sb_i_issue_valid = v;
        sb_i_dst_addr    = dst;
        sb_i_RegWrite    = rw;
        sb_i_MemRead     = ld;
        sb_i_rs_addr     = rs;
        sb_i_rs_used     = rsu;
        sb_i_rt_addr     = rt;
        sb_i_rt_used     = rtu;
    endtask

    initial begin
        sb_rst     = 1'b1;
        sb_i_ce    = 1'b1;
        sb_i_flush = 1'b0;
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        chk("rst_pending", sb_o_pending_cnt, 0);
        chk("rst_wb_valid", sb_o_wb_valid, 0);
        chk("rst_wb_addr", sb_o_wb_addr, 0);
        chk("rst_stall", sb_o_stall, 0);
        chk("rst_fwd_rs", sb_o_fwd_rs_sel, 0);
        chk("rst_fwd_rt", sb_o_fwd_rt_sel, 0);
        #10;
        sb_rst = 1'b0;
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("rel_ready", sb_o_issue_ready, 1);
        tick();

`ifndef SCOREBOARD_FORWARD_EN
        // RAW on r3: consumer directly behind producer stalls exactly two cycles
        issue(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("raw_prod_ready", sb_o_issue_ready, 1);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        chk("raw_stall1", sb_o_stall, 1);
        chk("raw_pending1", sb_o_pending_cnt, 1);
        chk("raw_fwd_tied", sb_o_fwd_rs_sel, 0);
        tick();
        chk("raw_stall2", sb_o_stall, 1);
        tick();
        chk("raw_stall3", sb_o_stall, 0);
        chk("raw_fire_ready", sb_o_issue_ready, 1);
        chk("raw_wb_valid", sb_o_wb_valid, 1);
        chk("raw_wb_addr", sb_o_wb_addr, 3);
        tick();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("raw_drain_pending", sb_o_pending_cnt, 0);
        chk("raw_drain_wb", sb_o_wb_valid, 0);
`else
        // ALU producer forwards from slot 0; load in slot 0 costs one stall
        issue(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        chk("fwd_alu_stall", sb_o_stall, 0);
        chk("fwd_alu_sel", sb_o_fwd_rs_sel, 1);
        tick();
        issue(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("fwd_rs_unused", sb_o_fwd_rs_sel, 0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        #1;
        chk("fwd_ld_stall", sb_o_stall, 1);
        tick();
        chk("fwd_ld_fire", sb_o_stall, 0);
        chk("fwd_ld_sel", sb_o_fwd_rt_sel, 2);
        tick();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        tick();
        chk("fwd_drain", sb_o_pending_cnt, 0);
`endif

        // r0 writes never occupy a slot
        issue(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        chk("r0_pending", sb_o_pending_cnt, 0);
        chk("r0_stall", sb_o_stall, 0);
        tick();

        // flush kills the r5 producer in slot 0 before it shifts
        issue(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sb_i_flush = 1'b1;
        #1;
        chk("flush_pre_pending", sb_o_pending_cnt, 1);
        chk("flush_ready", sb_o_issue_ready, 0);
        tick();
        sb_i_flush = 1'b0;
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("flush_pending", sb_o_pending_cnt, 0);
        chk("flush_cons_stall", sb_o_stall, 0);
        chk("flush_wb0", sb_o_wb_valid, 0);
        tick();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("flush_wb1", sb_o_wb_valid, 0);
        tick();
        chk("flush_wb2", sb_o_wb_valid, 0);

        // ce=0 freezes two live slots (r7 in slot 0, r6 in slot 1)
        issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        sb_i_ce = 1'b0;
        issue(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_pending", sb_o_pending_cnt, 2);
            chk("hold_ready", sb_o_issue_ready, 0);
            chk("hold_stall", sb_o_stall, 1);
            chk("hold_wb", sb_o_wb_valid, 0);
            tick();
        end
        sb_i_ce = 1'b1;
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
`ifndef SCOREBOARD_FORWARD_EN
        chk("hold_rt_haz", sb_o_stall, 1);
`endif
        chk("hold_after_pending", sb_o_pending_cnt, 2);
        sb_i_rt_used = 1'b0;
        #1;
        chk("hold_rt_unused", sb_o_issue_ready, 1);
        tick();
        chk("hold_wb6_valid", sb_o_wb_valid, 1);
        chk("hold_wb6_addr", sb_o_wb_addr, 6);
        chk("hold_cnt_a", sb_o_pending_cnt, 2);
        tick();
        chk("hold_wb7_addr", sb_o_wb_addr, 7);
        chk("hold_cnt_b", sb_o_pending_cnt, 1);
        tick();
        chk("hold_cnt_c", sb_o_pending_cnt, 0);
        chk("hold_wb_end", sb_o_wb_valid, 0);

        // flush with ce=0 kills slot 0 (r13) in place, slot 1 (r8) survives
        issue(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        sb_i_ce    = 1'b0;
        sb_i_flush = 1'b1;
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        sb_i_flush = 1'b0;
        #1;
        chk("ceflush_pending", sb_o_pending_cnt, 1);
        sb_i_ce = 1'b1;
        tick();
        chk("ceflush_wb_valid", sb_o_wb_valid, 1);
        chk("ceflush_wb_addr", sb_o_wb_addr, 8);
        tick();
        chk("ceflush_empty", sb_o_pending_cnt, 0);

        // reset mid-run with three live slots
        issue(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("mid_pending3", sb_o_pending_cnt, 3);
        chk("mid_wb_addr", sb_o_wb_addr, 10);
        #2;
        sb_rst = 1'b1;
        #1;
        chk("mid_rst_pending", sb_o_pending_cnt, 0);
        chk("mid_rst_wb_valid", sb_o_wb_valid, 0);
        chk("mid_rst_wb_addr", sb_o_wb_addr, 0);
        chk("mid_rst_stall", sb_o_stall, 0);
        tick();
        sb_rst = 1'b0;
        #1;
        chk("mid_rel_ready", sb_o_issue_ready, 1);
        chk("mid_rel_pending", sb_o_pending_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
